// File: rtl/exec_csr_unit_if.sv
// CSR access bus of exec_csr_unit: instruction read/write port plus the trap-write port.
// The master drives addresses and data; the slave (the CSR file) returns oReadData.
interface exec_csr_unit_if;
    logic        iRegWrite;
    logic [11:0] iWriteRegister;
    logic [31:0] iWriteData;
    logic [11:0] iReadRegister;
    logic [31:0] oReadData;
    logic        iRegWriteSimu;
    logic [31:0] iWriteDataUEPC;
    logic [31:0] iWriteDataUCAUSE;
    logic [31:0] iWriteDataUTVAL;

    modport master (
        output iRegWrite, iWriteRegister, iWriteData, iReadRegister,
        output iRegWriteSimu, iWriteDataUEPC, iWriteDataUCAUSE, iWriteDataUTVAL,
        input  oReadData
    );

    modport slave (
        input  iRegWrite, iWriteRegister, iWriteData, iReadRegister,
        input  iRegWriteSimu, iWriteDataUEPC, iWriteDataUCAUSE, iWriteDataUTVAL,
        output oReadData
    );
endinterface

// File: rtl/exec_csr_unit.sv
// Execute-stage cluster of the uniciclo RV32 core: ALU, branch comparator and user-mode CSR file.
// Define M_EXT_EN to enable the single-cycle M-extension ops (iControl codes 11-18).
module exec_csr_unit #(
    parameter logic [31:0] UTVEC_RESET = 32'h0000_0000
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [4:0]           iControl,
    input  logic [31:0]          iA,
    input  logic [31:0]          iB,
    output logic [31:0]          oResult,
    output logic                 oZero,
    input  logic [2:0]           iFunct3,
    input  logic [31:0]          iBrA,
    input  logic [31:0]          iBrB,
    output logic                 oBranch,
    exec_csr_unit_if.slave       csrBus,
    output logic [31:0]          oReadDataUSTATUS,
    output logic [31:0]          oReadDataUTVEC,
    output logic [31:0]          oReadDataUEPC,
    output logic [31:0]          oReadDataUTVAL,
    input  logic [4:0]           iRegDispSelect,
    input  logic [4:0]           iVGASelect,
    output logic [31:0]          oRegDisp,
    output logic [31:0]          oVGARead
);

    localparam logic [11:0] ADDR_USTATUS  = 12'h000;
    localparam logic [11:0] ADDR_UIE      = 12'h004;
    localparam logic [11:0] ADDR_UTVEC    = 12'h005;
    localparam logic [11:0] ADDR_USCRATCH = 12'h040;
    localparam logic [11:0] ADDR_UEPC     = 12'h041;
    localparam logic [11:0] ADDR_UCAUSE   = 12'h042;
    localparam logic [11:0] ADDR_UTVAL    = 12'h043;
    localparam logic [11:0] ADDR_UIP      = 12'h044;

    typedef enum logic [4:0] {
        OP_AND = 5'd0,  OP_OR   = 5'd1,  OP_XOR    = 5'd2,  OP_ADD   = 5'd3,
        OP_SUB = 5'd4,  OP_SLT  = 5'd5,  OP_SLTU   = 5'd6,  OP_SLL   = 5'd7,
        OP_SRL = 5'd8,  OP_SRA  = 5'd9,  OP_LUI    = 5'd10, OP_MUL   = 5'd11,
        OP_MULH = 5'd12, OP_MULHSU = 5'd13, OP_MULHU = 5'd14, OP_DIV = 5'd15,
        OP_DIVU = 5'd16, OP_REM = 5'd17, OP_REMU   = 5'd18
    } aluOp_t;

    logic [31:0] ustatus, uie, utvec, uscratch, uepc, ucause, utval, uip;
    logic [31:0] aluResult;

`ifdef M_EXT_EN
    logic [63:0] prodSS, prodSU, prodUU;
    logic        divByZero, divOverflow;

    assign prodSS      = $signed({{32{iA[31]}}, iA}) * $signed({{32{iB[31]}}, iB});
    assign prodSU      = $signed({{32{iA[31]}}, iA}) * $signed({32'b0, iB});
    assign prodUU      = {32'b0, iA} * {32'b0, iB};
    assign divByZero   = (iB == 32'h0);
    assign divOverflow = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
`endif

    always_comb begin
        // NOTE: default assigned first so every path drives aluResult and no latch is inferred.
        aluResult = 32'h0;
        case (aluOp_t'(iControl))
            OP_AND:  aluResult = iA & iB;
            OP_OR:   aluResult = iA | iB;
            OP_XOR:  aluResult = iA ^ iB;
            OP_ADD:  aluResult = iA + iB;
            OP_SUB:  aluResult = iA - iB;
            OP_SLT:  aluResult = {31'b0, ($signed(iA) < $signed(iB))};
            OP_SLTU: aluResult = {31'b0, (iA < iB)};
            OP_SLL:  aluResult = iA << iB[4:0];
            OP_SRL:  aluResult = iA >> iB[4:0];
            OP_SRA:  aluResult = $signed(iA) >>> iB[4:0];
            OP_LUI:  aluResult = iB;
`ifdef M_EXT_EN
            OP_MUL:    aluResult = prodUU[31:0];
            OP_MULH:   aluResult = prodSS[63:32];
            OP_MULHSU: aluResult = prodSU[63:32];
            OP_MULHU:  aluResult = prodUU[63:32];
            OP_DIV:    aluResult = divByZero ? 32'hFFFF_FFFF :
                                   divOverflow ? 32'h8000_0000 : $signed(iA) / $signed(iB);
            OP_DIVU:   aluResult = divByZero ? 32'hFFFF_FFFF : iA / iB;
            OP_REM:    aluResult = divByZero ? iA :
                                   divOverflow ? 32'h0 : $signed(iA) % $signed(iB);
            OP_REMU:   aluResult = divByZero ? iA : iA % iB;
`endif
            default: aluResult = 32'h0;
        endcase
    end

    assign oResult = aluResult;
    assign oZero   = (aluResult == 32'h0);

    always_comb begin
        oBranch = 1'b0;
        case (iFunct3)
            3'b000:  oBranch = (iBrA == iBrB);
            3'b001:  oBranch = (iBrA != iBrB);
            3'b100:  oBranch = ($signed(iBrA) < $signed(iBrB));
            3'b101:  oBranch = ($signed(iBrA) >= $signed(iBrB));
            3'b110:  oBranch = (iBrA < iBrB);
            3'b111:  oBranch = (iBrA >= iBrB);
            default: oBranch = 1'b0;
        endcase
    end

    // Trap write follows the instruction write so its assignment wins on uepc/ucause/utval.
    always_ff @(posedge iCLK) begin
        // NOTE: the CSR file is eight plain flops, so every entry is reset rather than left undefined.
        if (!iRST) begin
            ustatus  <= 32'h0;
            uie      <= 32'h0;
            utvec    <= UTVEC_RESET;
            uscratch <= 32'h0;
            uepc     <= 32'h0;
            ucause   <= 32'h0;
            utval    <= 32'h0;
            uip      <= 32'h0;
        end else begin
            // NOTE: non-blocking updates keep reads in this cycle on the old value.
            if (csrBus.iRegWrite) begin
                case (csrBus.iWriteRegister)
                    ADDR_USTATUS:  ustatus  <= csrBus.iWriteData;
                    ADDR_UIE:      uie      <= csrBus.iWriteData;
                    ADDR_UTVEC:    utvec    <= csrBus.iWriteData;
                    ADDR_USCRATCH: uscratch <= csrBus.iWriteData;
                    ADDR_UEPC:     uepc     <= csrBus.iWriteData;
                    ADDR_UCAUSE:   ucause   <= csrBus.iWriteData;
                    ADDR_UTVAL:    utval    <= csrBus.iWriteData;
                    ADDR_UIP:      uip      <= csrBus.iWriteData;
                    default: ;
                endcase
            end
            if (csrBus.iRegWriteSimu) begin
                uepc   <= csrBus.iWriteDataUEPC;
                ucause <= csrBus.iWriteDataUCAUSE;
                utval  <= csrBus.iWriteDataUTVAL;
            end
        end
    end

    always_comb begin
        csrBus.oReadData = 32'h0;
        case (csrBus.iReadRegister)
            ADDR_USTATUS:  csrBus.oReadData = ustatus;
            ADDR_UIE:      csrBus.oReadData = uie;
            ADDR_UTVEC:    csrBus.oReadData = utvec;
            ADDR_USCRATCH: csrBus.oReadData = uscratch;
            ADDR_UEPC:     csrBus.oReadData = uepc;
            ADDR_UCAUSE:   csrBus.oReadData = ucause;
            ADDR_UTVAL:    csrBus.oReadData = utval;
            ADDR_UIP:      csrBus.oReadData = uip;
            default:       csrBus.oReadData = 32'h0;
        endcase
    end

    function automatic logic [31:0] dispSelect(input logic [4:0] index);
        logic [31:0] value;
        value = 32'h0;
        case (index)
            5'd0:    value = ustatus;
            5'd1:    value = uie;
            5'd2:    value = utvec;
            5'd3:    value = uscratch;
            5'd4:    value = uepc;
            5'd5:    value = ucause;
            5'd6:    value = utval;
            5'd7:    value = uip;
            default: value = 32'h0;
        endcase
        return value;
    endfunction

    assign oRegDisp         = dispSelect(iRegDispSelect);
    assign oVGARead         = dispSelect(iVGASelect);
    assign oReadDataUSTATUS = ustatus;
    assign oReadDataUTVEC   = utvec;
    assign oReadDataUEPC    = uepc;
    assign oReadDataUTVAL   = utval;

endmodule

// File: tb/tb_exec_csr_unit.sv
// Self-checking bench for exec_csr_unit: directed corner cases then random stimulus vs a reference model.
// Expected M-extension results follow the M_EXT_EN define of the build.
module tb_exec_csr_unit;

    localparam logic [31:0] TB_UTVEC = 32'h0000_1000;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [4:0]  iControl;
    logic [31:0] iA, iB, oResult;
    logic        oZero;
    logic [2:0]  iFunct3;
    logic [31:0] iBrA, iBrB;
    logic        oBranch;
    logic [31:0] oReadDataUSTATUS, oReadDataUTVEC, oReadDataUEPC, oReadDataUTVAL;
    logic [4:0]  iRegDispSelect, iVGASelect;
    logic [31:0] oRegDisp, oVGARead;

    exec_csr_unit_if bus ();

    exec_csr_unit #(.UTVEC_RESET(TB_UTVEC)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iControl(iControl), .iA(iA), .iB(iB), .oResult(oResult), .oZero(oZero),
        .iFunct3(iFunct3), .iBrA(iBrA), .iBrB(iBrB), .oBranch(oBranch),
        .csrBus(bus.slave),
        .oReadDataUSTATUS(oReadDataUSTATUS), .oReadDataUTVEC(oReadDataUTVEC),
        .oReadDataUEPC(oReadDataUEPC), .oReadDataUTVAL(oReadDataUTVAL),
        .iRegDispSelect(iRegDispSelect), .iVGASelect(iVGASelect),
        .oRegDisp(oRegDisp), .oVGARead(oVGARead)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    // Reference CSR state: keyed by architectural address; unmapped addresses are simply absent.
    logic [31:0] csrModel [logic [11:0]];
    logic [11:0] dispAddr [8] = '{12'h000, 12'h004, 12'h005, 12'h040,
                                  12'h041, 12'h042, 12'h043, 12'h044};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] csrRead(input logic [11:0] addr);
        return csrModel.exists(addr) ? csrModel[addr] : 32'h0;
    endfunction

    function automatic logic [31:0] dispRef(input logic [4:0] index);
        return (index < 8) ? csrRead(dispAddr[index]) : 32'h0;
    endfunction

    function automatic logic [31:0] aluRef(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        int unsigned sh = b[4:0];
        longint unsigned ua64 = {32'b0, a};
        longint unsigned ub64 = {32'b0, b};
        longint pss = longint'(sa) * longint'(sb);
        longint psu = longint'(sa) * longint'(ub64);
        longint unsigned puu = ua64 * ub64;
        case (op)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a ^ b;
            5'd3:  return a + b;
            5'd4:  return a - b;
            5'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd6:  return (a < b) ? 32'd1 : 32'd0;
            5'd7:  return a << sh;
            5'd8:  return a >> sh;
            5'd9:  return 32'(sa >>> sh);
            5'd10: return b;
`ifdef M_EXT_EN
            5'd11: return puu[31:0];
            5'd12: return 32'(pss >>> 32);
            5'd13: return 32'(psu >>> 32);
            5'd14: return 32'(puu >> 32);
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && sb == -1) ? a : 32'(sa / sb);
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: return (b == 0) ? a : (a == 32'h8000_0000 && sb == -1) ? 32'h0 : 32'(sa % sb);
            5'd18: return (b == 0) ? a : a % b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic branchRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Advance one clock edge, updating the model from the inputs held across that edge.
    task automatic tick();
        if (!iRST) begin
            csrModel.delete();
            foreach (dispAddr[i]) csrModel[dispAddr[i]] = 32'h0;
            csrModel[12'h005] = TB_UTVEC;
        end else begin
            if (bus.iRegWrite && csrModel.exists(bus.iWriteRegister))
                csrModel[bus.iWriteRegister] = bus.iWriteData;
            if (bus.iRegWriteSimu) begin
                csrModel[12'h041] = bus.iWriteDataUEPC;
                csrModel[12'h042] = bus.iWriteDataUCAUSE;
                csrModel[12'h043] = bus.iWriteDataUTVAL;
            end
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkTaps(input string tag);
        check({tag, " ustatus tap"}, oReadDataUSTATUS, csrRead(12'h000));
        check({tag, " utvec tap"},   oReadDataUTVEC,   csrRead(12'h005));
        check({tag, " uepc tap"},    oReadDataUEPC,    csrRead(12'h041));
        check({tag, " utval tap"},   oReadDataUTVAL,   csrRead(12'h043));
    endtask

    task automatic aluCase(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
        iControl = op; iA = a; iB = b;
        #1;
        check(tag, oResult, expected);
        check({tag, " model"}, oResult, aluRef(op, a, b));
    endtask

    task automatic branchCase(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic expected);
        iFunct3 = f3; iBrA = a; iBrB = b;
        #1;
        check(tag, {31'b0, oBranch}, {31'b0, expected});
    endtask

    initial begin
        iRST = 1'b0; iControl = '0; iA = '0; iB = '0; iFunct3 = '0; iBrA = '0; iBrB = '0;
        iRegDispSelect = '0; iVGASelect = '0;
        bus.iReadRegister = '0; bus.iRegWrite = 1'b1; bus.iWriteRegister = 12'h040;
        bus.iWriteData = 32'hFFFF_FFFF; bus.iRegWriteSimu = 1'b1;
        bus.iWriteDataUEPC = 32'h1111_1111; bus.iWriteDataUCAUSE = 32'h2222_2222;
        bus.iWriteDataUTVAL = 32'h3333_3333;

        // Reset with both write enables asserted: reset must win.
        tick();
        tick();
        bus.iRegWrite = 1'b0; bus.iRegWriteSimu = 1'b0;
        foreach (dispAddr[i]) begin
            bus.iReadRegister = dispAddr[i];
            #1;
            check($sformatf("reset read %h", dispAddr[i]), bus.oReadData,
                  (dispAddr[i] == 12'h005) ? TB_UTVEC : 32'h0);
        end
        checkTaps("reset");
        iRegDispSelect = 5'd9; iVGASelect = 5'd2;
        #1;
        check("reset disp 9", oRegDisp, 32'h0);
        check("reset vga utvec", oVGARead, TB_UTVEC);
        iRST = 1'b1;

        aluCase("SUB 5-7", 5'd4, 32'd5, 32'd7, 32'hFFFF_FFFE);
        check("SUB zero flag", {31'b0, oZero}, 32'h0);
        aluCase("SRA 80000000>>>4", 5'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
        aluCase("SLTU FFFFFFFF<1", 5'd6, 32'hFFFF_FFFF, 32'd1, 32'h0);
        aluCase("SLT FFFFFFFF<1", 5'd5, 32'hFFFF_FFFF, 32'd1, 32'h1);
        aluCase("XOR equal", 5'd2, 32'h1234_5678, 32'h1234_5678, 32'h0);
        check("XOR zero flag", {31'b0, oZero}, 32'h1);
        aluCase("ADD wrap", 5'd3, 32'hFFFF_FFFF, 32'd2, 32'h1);
        aluCase("LUI pass", 5'd10, 32'hDEAD_0000, 32'hABCD_E000, 32'hABCD_E000);
        aluCase("code 31", 5'd31, 32'h1, 32'h1, 32'h0);
`ifdef M_EXT_EN
        aluCase("MULH min*min", 5'd12, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        aluCase("DIV 7/0", 5'd15, 32'd7, 32'd0, 32'hFFFF_FFFF);
        aluCase("REM -7/2", 5'd17, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        aluCase("DIV overflow", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        aluCase("REM overflow", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        aluCase("REMU x/0", 5'd18, 32'd9, 32'd0, 32'd9);
`else
        aluCase("MULH disabled", 5'd12, 32'h8000_0000, 32'h8000_0000, 32'h0);
        aluCase("DIV disabled", 5'd15, 32'd7, 32'd0, 32'h0);
        aluCase("MUL disabled", 5'd11, 32'd3, 32'd5, 32'h0);
`endif

        branchCase("BLT", 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        branchCase("BLTU", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
        branchCase("BGE", 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
        branchCase("BGEU", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        branchCase("BEQ eq", 3'b000, 32'h55, 32'h55, 1'b1);
        branchCase("BNE eq", 3'b001, 32'h55, 32'h55, 1'b0);
        branchCase("funct3 010", 3'b010, 32'h55, 32'h55, 1'b0);
        branchCase("funct3 011", 3'b011, 32'd1, 32'd2, 1'b0);

        // Read-during-write: old value now, new value after the edge.
        bus.iRegWrite = 1'b1; bus.iWriteRegister = 12'h040; bus.iWriteData = 32'hCAFE_BABE;
        bus.iReadRegister = 12'h040;
        #1;
        check("uscratch same cycle", bus.oReadData, 32'h0);
        tick();
        bus.iRegWrite = 1'b0;
        #1;
        check("uscratch next cycle", bus.oReadData, 32'hCAFE_BABE);
        bus.iRegWrite = 1'b1; bus.iWriteRegister = 12'h7C0; bus.iWriteData = 32'h1234_5678;
        tick();
        bus.iRegWrite = 1'b0; bus.iReadRegister = 12'h7C0;
        #1;
        check("unmapped 7C0", bus.oReadData, 32'h0);

        // Trap write collides with an instruction write to uepc.
        bus.iRegWriteSimu = 1'b1; bus.iWriteDataUEPC = 32'h400; bus.iWriteDataUCAUSE = 32'h2;
        bus.iWriteDataUTVAL = 32'h13;
        bus.iRegWrite = 1'b1; bus.iWriteRegister = 12'h041; bus.iWriteData = 32'h5;
        tick();
        bus.iRegWrite = 1'b0; bus.iRegWriteSimu = 1'b0; bus.iReadRegister = 12'h041;
        #1;
        check("trap wins uepc", bus.oReadData, 32'h400);
        bus.iReadRegister = 12'h042;
        #1;
        check("trap ucause", bus.oReadData, 32'h2);
        checkTaps("trap");

        // Trap write alongside an instruction write to another CSR: both land.
        bus.iRegWriteSimu = 1'b1; bus.iWriteDataUEPC = 32'h800;
        bus.iRegWrite = 1'b1; bus.iWriteRegister = 12'h004; bus.iWriteData = 32'hA5;
        tick();
        bus.iRegWrite = 1'b0; bus.iRegWriteSimu = 1'b0; bus.iReadRegister = 12'h004;
        #1;
        check("uie with trap", bus.oReadData, 32'hA5);
        check("uepc second trap", oReadDataUEPC, 32'h800);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra, rb;
            logic [11:0] addrPick;
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom();
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            iControl = 5'($urandom_range(0, 31)); iA = ra; iB = rb;
            iFunct3 = 3'($urandom_range(0, 7));
            iBrA = $urandom(); iBrB = ($urandom_range(0, 3) == 0) ? iBrA : $urandom();
            addrPick = ($urandom_range(0, 4) == 0) ? 12'($urandom()) : dispAddr[$urandom_range(0, 7)];
            bus.iRegWrite = 1'($urandom_range(0, 1)); bus.iWriteRegister = addrPick;
            bus.iWriteData = $urandom();
            bus.iReadRegister = ($urandom_range(0, 4) == 0) ? 12'($urandom()) : dispAddr[$urandom_range(0, 7)];
            bus.iRegWriteSimu = ($urandom_range(0, 3) == 0);
            bus.iWriteDataUEPC = $urandom(); bus.iWriteDataUCAUSE = $urandom();
            bus.iWriteDataUTVAL = $urandom();
            iRegDispSelect = 5'($urandom_range(0, 31)); iVGASelect = 5'($urandom_range(0, 31));
            iRST = ($urandom_range(0, 49) != 0);
            #1;
            check($sformatf("rand alu op%0d", iControl), oResult, aluRef(iControl, iA, iB));
            check("rand zero", {31'b0, oZero}, {31'b0, aluRef(iControl, iA, iB) == 32'h0});
            check($sformatf("rand branch f3=%0d", iFunct3), {31'b0, oBranch},
                  {31'b0, branchRef(iFunct3, iBrA, iBrB)});
            check($sformatf("rand read %h", bus.iReadRegister), bus.oReadData, csrRead(bus.iReadRegister));
            check("rand disp", oRegDisp, dispRef(iRegDispSelect));
            check("rand vga", oVGARead, dispRef(iVGASelect));
            tick();
            checkTaps("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
